// File: rtl/des_key_scheduler.sv
// rtl/des_key_scheduler.sv - DES round-subkey sequencer; decrypt order built with DES_KEYSCHED_DECRYPT_EN
module des_key_scheduler (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [55:0] key_in,
`ifdef DES_KEYSCHED_DECRYPT_EN
    input  logic        decrypt,
`endif
    output logic        busy,
    output logic [47:0] subkey,
    output logic        subkey_valid,
    input  logic        subkey_ready,
    output logic [3:0]  round,
    output logic        done
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    // PC2 selection: entry i names the 1-based DES bit of C||D that feeds subkey bit i+1.
    localparam int PC2_TAB [48] = '{
        14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
        23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    state_t      state_q;
    state_t      state_d;
    logic [55:0] cd_q;
    logic [3:0]  step_q;
    logic [3:0]  round_q;
    logic        mode_q;
    logic        done_r;

    logic        load;
    logic        advance;
    logic        finish;
    logic        start_dec;
    logic        rot_one;
    logic [55:0] cd_next;

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic one);
        return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
    endfunction

`ifdef DES_KEYSCHED_DECRYPT_EN
    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic one);
        return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
    endfunction
`endif

    function automatic logic [47:0] pc2(input logic [55:0] c);
        logic [47:0] k;
        k = '0;
        for (int i = 0; i < 48; i++) begin
            k[47-i] = c[56-PC2_TAB[i]];
        end
        return k;
    endfunction

`ifdef DES_KEYSCHED_DECRYPT_EN
    assign start_dec = decrypt;
`else
    assign start_dec = 1'b0;
    assign mode_q    = 1'b0;
`endif

    // Shift-by-one transitions: encrypt into K2/K9/K16, decrypt out of K16/K9/K2.
    assign rot_one = (step_q == 4'd0) || (step_q == 4'd7) || (step_q == 4'd14);

`ifdef DES_KEYSCHED_DECRYPT_EN
    assign cd_next = mode_q ? {rotr28(cd_q[55:28], rot_one), rotr28(cd_q[27:0], rot_one)}
                            : {rotl28(cd_q[55:28], rot_one), rotl28(cd_q[27:0], rot_one)};
`else
    assign cd_next = {rotl28(cd_q[55:28], rot_one), rotl28(cd_q[27:0], rot_one)};
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode; start only matters in IDLE, ready only in PRESENT.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = PRESENT;
                end
            end
            PRESENT: begin
                if (subkey_ready) begin
                    if (step_q == 4'd15) begin
                        finish  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Key halves, step/round counters, direction and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            cd_q    <= '0;
            step_q  <= '0;
            round_q <= '0;
            done_r  <= 1'b0;
`ifdef DES_KEYSCHED_DECRYPT_EN
            mode_q  <= 1'b0;
`endif
        end else begin
            done_r <= finish;
            if (load) begin
                step_q <= '0;
`ifdef DES_KEYSCHED_DECRYPT_EN
                mode_q <= start_dec;
`endif
                if (start_dec) begin
                    cd_q    <= key_in;
                    round_q <= 4'd15;
                end else begin
                    cd_q    <= {rotl28(key_in[55:28], 1'b1), rotl28(key_in[27:0], 1'b1)};
                    round_q <= 4'd0;
                end
            end else if (advance) begin
                step_q  <= step_q + 4'd1;
                cd_q    <= cd_next;
                round_q <= mode_q ? (round_q - 4'd1) : (round_q + 4'd1);
            end
        end
    end

    assign busy         = (state_q == PRESENT);
    assign subkey_valid = (state_q == PRESENT);
    assign subkey       = pc2(cd_q);
    assign round        = round_q;
    assign done         = done_r;

endmodule

// File: tb/tb_des_key_scheduler.sv
// tb/tb_des_key_scheduler.sv - directed known-answer bench for des_key_scheduler
module tb_des_key_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [55:0] key_in;
    logic        decrypt;
    logic        busy;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round;
    logic        done;

    int errors = 0;
    int checks = 0;

    localparam logic [55:0] KEY = 56'hF0CCAAF556678F;
    localparam logic [47:0] KAT [16] = '{
        48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
        48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
        48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
        48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };

    des_key_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .key_in       (key_in),
`ifdef DES_KEYSCHED_DECRYPT_EN
        .decrypt      (decrypt),
`endif
        .busy         (busy),
        .subkey       (subkey),
        .subkey_valid (subkey_valid),
        .subkey_ready (subkey_ready),
        .round        (round),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic begin_schedule(input logic dec);
        key_in  = KEY;
        decrypt = dec;
        start   = 1'b1;
        tick();
        start   = 1'b0;
        check("busy_after_start", {63'd0, busy}, 64'd1);
    endtask

    task automatic run_schedule(input logic dec, input int stall_at, input int poke_at, input bit chain);
        int r;
        subkey_ready = 1'b1;
        for (int idx = 0; idx < 16; idx++) begin
            r = dec ? 15 - idx : idx;
            if (idx == stall_at) begin
                subkey_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    tick();
                    check($sformatf("stall%0d_valid", s), {63'd0, subkey_valid}, 64'd1);
                    check($sformatf("stall%0d_round", s), {60'd0, round}, 64'(r));
                    check($sformatf("stall%0d_subkey", s), {16'd0, subkey}, {16'd0, KAT[r]});
                end
                subkey_ready = 1'b1;
            end
            if (idx == poke_at) begin
                start   = 1'b1;
                key_in  = 56'h0;
                decrypt = ~dec;
            end
            check($sformatf("valid_i%0d", idx), {63'd0, subkey_valid}, 64'd1);
            check($sformatf("round_i%0d", idx), {60'd0, round}, 64'(r));
            check($sformatf("subkey_i%0d", idx), {16'd0, subkey}, {16'd0, KAT[r]});
            check($sformatf("nodone_i%0d", idx), {63'd0, done}, 64'd0);
            tick();
            start  = 1'b0;
            key_in = KEY;
        end
        check("done_pulse", {63'd0, done}, 64'd1);
        check("busy_end", {63'd0, busy}, 64'd0);
        check("valid_end", {63'd0, subkey_valid}, 64'd0);
        if (chain) begin
            key_in  = KEY;
            decrypt = dec;
            start   = 1'b1;
        end
        tick();
        start = 1'b0;
        check("done_single", {63'd0, done}, 64'd0);
        if (chain) begin
            check("chain_busy", {63'd0, busy}, 64'd1);
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        key_in       = KEY;
        decrypt      = 1'b0;
        subkey_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_valid", {63'd0, subkey_valid}, 64'd0);
        check("rst_subkey", {16'd0, subkey}, 64'd0);
        check("rst_round", {60'd0, round}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);

        // rst and start together: reset wins
        subkey_ready = 1'b1;
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", {63'd0, busy}, 64'd0);
        tick();
        check("rst_start_idle", {63'd0, subkey_valid}, 64'd0);

        // known answer, chained back-to-back into a second run
        begin_schedule(1'b0);
        run_schedule(1'b0, -1, -1, 1'b1);
        run_schedule(1'b0, -1, -1, 1'b0);

        // backpressure at round 3
        begin_schedule(1'b0);
        run_schedule(1'b0, 3, -1, 1'b0);

        // start while busy at round 7
        begin_schedule(1'b0);
        run_schedule(1'b0, -1, 7, 1'b0);

        // reset at round 9
        begin_schedule(1'b0);
        for (int idx = 0; idx < 9; idx++) begin
            check($sformatf("pre_rst_subkey_i%0d", idx), {16'd0, subkey}, {16'd0, KAT[idx]});
            tick();
        end
        check("pre_rst_round", {60'd0, round}, 64'd9);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_valid", {63'd0, subkey_valid}, 64'd0);
        check("abort_round", {60'd0, round}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        tick();
        check("abort_no_done", {63'd0, done}, 64'd0);
        begin_schedule(1'b0);
        run_schedule(1'b0, -1, -1, 1'b0);

`ifdef DES_KEYSCHED_DECRYPT_EN
        begin_schedule(1'b1);
        run_schedule(1'b1, 4, 6, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
